par_to_ser: RTL and testbench

Parallel-to-serial transmitter that feeds the serial input of the capture shift register in the renzym user-project datapath. It accepts one DATA_WIDTH-bit word per valid/ready handshake and drives it out MSB-first, one bit per clock. After DATA_WIDTH bit cycles, a DATA_WIDTH-wide serial-in/parallel-out register clocked on the same edge holds the original word. Back-to-back words stream without gap cycles.

---
 rtl/par_to_ser_pkg.sv | 25 ++
 rtl/par_to_ser.sv | 88 ++++++++
 tb/tb_par_to_ser.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/par_to_ser_pkg.sv
// Shared definitions for the par_to_ser transmitter.
// Optional feature macro: PAR_TO_SER_PARITY_EN (appends an even-parity bit to each frame).
package par_to_ser_pkg;

    // Two-state FSM encoding.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Bits per frame on the serial line: data bits plus optional parity bit.
    function automatic int unsigned frame_len(input int unsigned data_width);
`ifdef PAR_TO_SER_PARITY_EN
        return data_width + 1;
`else
        return data_width;
`endif
    endfunction

    // Bit-counter width; wide enough to hold frame_len-1 in either build.
    function automatic int unsigned cnt_width(input int unsigned data_width);
        return $clog2(data_width + 1);
    endfunction

endpackage

// File: rtl/par_to_ser.sv
// Parallel-to-serial transmitter, MSB first, one bit per clock, zero-gap streaming.
// Optional feature macro: PAR_TO_SER_PARITY_EN (even-parity bit sent after the LSB).
module par_to_ser
    import par_to_ser_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  ser_out,
    output logic                  ser_vld,
    output logic                  ser_last
);

    localparam int unsigned FrameLen = frame_len(DATA_WIDTH);
    localparam int unsigned CntW     = cnt_width(DATA_WIDTH);
    localparam logic [CntW-1:0] CntLoad = CntW'(FrameLen - 1);

    state_e                state_q, state_d;
    logic [FrameLen-1:0]   shreg_q, shreg_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [FrameLen-1:0]   load_word;
    logic                  accept;

    // Frame image loaded on accept; parity (when present) rides in the LSB so it falls out last.
`ifdef PAR_TO_SER_PARITY_EN
    assign load_word = {in_data, ^in_data};
`else
    assign load_word = in_data;
`endif

    // Outputs decode registered state only; in_ready has no path from in_valid.
    assign ser_vld  = (state_q == ST_SHIFT);
    assign ser_last = ser_vld && (cnt_q == '0);
    assign ser_out  = ser_vld & shreg_q[FrameLen-1];
    assign in_ready = (state_q == ST_IDLE) || ser_last;
    assign accept   = in_valid && in_ready;

    // Next-state: load on accept, otherwise shift with zero fill and count down to zero.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SHIFT;
                    shreg_d = load_word;
                    cnt_d   = CntLoad;
                end
            end
            ST_SHIFT: begin
                if (accept) begin
                    // Only reachable in the last-bit cycle: chain the next frame with no gap.
                    shreg_d = load_word;
                    cnt_d   = CntLoad;
                end else begin
                    shreg_d = {shreg_q[FrameLen-2:0], 1'b0};
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any frame in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_par_to_ser.sv
// Self-checking bench for par_to_ser (DATA_WIDTH=8 with model, DATA_WIDTH=2 corner).
// Honours PAR_TO_SER_PARITY_EN when defined for the build.
module tb_par_to_ser;

    localparam int DW = 8;
`ifdef PAR_TO_SER_PARITY_EN
    localparam int FL = DW + 1;
`else
    localparam int FL = DW;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready, ser_out, ser_vld, ser_last;
    logic [1:0]    in2_data;
    logic          in2_valid;
    logic          in2_ready, ser2_out, ser2_vld, ser2_last;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    par_to_ser #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .ser_out(ser_out), .ser_vld(ser_vld), .ser_last(ser_last)
    );

    par_to_ser #(.DATA_WIDTH(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .in_data(in2_data), .in_valid(in2_valid),
        .in_ready(in2_ready), .ser_out(ser2_out), .ser_vld(ser2_vld), .ser_last(ser2_last)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Whole frame as it should appear on the wire, MSB first.
    function automatic logic [FL-1:0] frame_of(input logic [DW-1:0] w);
`ifdef PAR_TO_SER_PARITY_EN
        return {w, ^w};
`else
        return w;
`endif
    endfunction

    // Model: queue of {bit,last} still owed to the wire; front entry is the current cycle.
    logic [1:0] mq[$];
    logic       m_rdy;
    logic [FL-1:0] m_f;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
        end else begin
            m_rdy = (mq.size() <= 1);
            if (mq.size() > 0) void'(mq.pop_front());
            if (in_valid && m_rdy) begin
                m_f = frame_of(in_data);
                for (int i = FL - 1; i >= 0; i--) mq.push_back({m_f[i], i == 0});
            end
        end
    end

    // Compare every cycle against the model.
    logic c_v, c_o, c_l, c_r;
    always @(negedge clk) begin
        c_v = (mq.size() > 0);
        c_o = c_v ? mq[0][1] : 1'b0;
        c_l = c_v ? mq[0][0] : 1'b0;
        c_r = (mq.size() <= 1);
        chk("cyc_ser_vld", ser_vld, c_v);
        chk("cyc_ser_out", ser_out, c_o);
        chk("cyc_ser_last", ser_last, c_l);
        chk("cyc_in_ready", in_ready, c_r);
    end

    // Downstream SIPO capture: one frame word per ser_last, plus contiguous-valid run length.
    logic [FL-1:0] sh = '0;
    logic [FL-1:0] frames[$];
    int run = 0;
    int max_run = 0;
    always @(negedge clk) begin
        if (ser_vld) begin
            sh = {sh[FL-2:0], ser_out};
            if (ser_last) frames.push_back(sh);
            run++;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
    end

    task automatic send(input logic [DW-1:0] w);
        int n = 0;
        in_data  = w;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready 0 expected 1 at %0t", $time);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (ser_vld && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", ser_vld, 1'b0);
    endtask

    function automatic logic [FL-1:0] frame_at(input int idx);
        return (idx < frames.size()) ? frames[idx] : 'x;
    endfunction

    logic [FL-1:0] pat_a5, pat_07, pat_03;

    initial begin
`ifdef PAR_TO_SER_PARITY_EN
        pat_a5 = 9'h14A;  // A5, even number of ones -> parity 0
        pat_07 = 9'h00F;  // 07 -> parity 1
        pat_03 = 9'h006;  // 03 -> parity 0
`else
        pat_a5 = 8'hA5;
        pat_07 = 8'h07;
        pat_03 = 8'h03;
`endif
        reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in2_valid = 1'b0; in2_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_ser_vld", ser_vld, 1'b0);
        chk("rst2_in_ready", in2_ready, 1'b1);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single word A5, literal bit pattern.
        frames.delete();
        send(8'hA5);
        for (int i = 0; i < FL; i++) begin
            @(negedge clk);
            chk("a5_bit", ser_out, pat_a5[FL-1-i]);
            chk("a5_last", ser_last, i == FL - 1);
        end
        @(negedge clk);
        chk("a5_idle_after", ser_vld, 1'b0);
        chk("a5_nframes", frames.size(), 1);
        chk("a5_word", frame_at(0), pat_a5);

        // Back-to-back 3C then FF: no gap.
        frames.delete();
        max_run = 0;
        send(8'h3C);
        send(8'hFF);
        wait_idle();
        chk("b2b_nframes", frames.size(), 2);
        chk("b2b_word0", frame_at(0), frame_of(8'h3C));
        chk("b2b_word1", frame_at(1), frame_of(8'hFF));
        chk("b2b_contig", max_run, 2 * FL);

        // Backpressure: valid held across three words.
        frames.delete();
        send(8'h11);
        send(8'h22);
        send(8'h33);
        wait_idle();
        chk("bp_nframes", frames.size(), 3);
        chk("bp_word0", frame_at(0), frame_of(8'h11));
        chk("bp_word1", frame_at(1), frame_of(8'h22));
        chk("bp_word2", frame_at(2), frame_of(8'h33));

        // Parity-sensitive words.
        frames.delete();
        send(8'h07);
        wait_idle();
        send(8'h03);
        wait_idle();
        chk("w07_word", frame_at(0), pat_07);
        chk("w03_word", frame_at(1), pat_03);

        // Reset mid-frame: outputs clear immediately.
        send(8'hFF);
        repeat (3) @(negedge clk);
        #2;
        chk("pre_rst_out", ser_out, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("arst_ser_vld", ser_vld, 1'b0);
        chk("arst_ser_out", ser_out, 1'b0);
        chk("arst_ser_last", ser_last, 1'b0);
        chk("arst_in_ready", in_ready, 1'b1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        frames.delete();
        repeat (4) @(negedge clk);
        chk("post_rst_quiet", frames.size(), 0);

        // DATA_WIDTH=2 corner: 2'b10.
        in2_data  = 2'b10;
        in2_valid = 1'b1;
        @(posedge clk);
        #1;
        in2_valid = 1'b0;
        @(negedge clk);
        chk("w2_bit0", ser2_out, 1'b1);
        chk("w2_vld0", ser2_vld, 1'b1);
        chk("w2_last0", ser2_last, 1'b0);
        chk("w2_rdy0", in2_ready, 1'b0);
        @(negedge clk);
        chk("w2_bit1", ser2_out, 1'b0);
`ifdef PAR_TO_SER_PARITY_EN
        chk("w2_last1", ser2_last, 1'b0);
        chk("w2_rdy1", in2_ready, 1'b0);
        @(negedge clk);
        chk("w2_par", ser2_out, 1'b1);
        chk("w2_last_par", ser2_last, 1'b1);
        chk("w2_rdy_par", in2_ready, 1'b1);
`else
        chk("w2_last1", ser2_last, 1'b1);
        chk("w2_rdy1", in2_ready, 1'b1);
`endif
        @(negedge clk);
        chk("w2_idle", ser2_vld, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
